fifo_word_unpacker: RTL and testbench
=====================================

Name: fifo_word_unpacker

Overview:
Drain-side companion to the team's show-ahead FIFO. It pops DATA_WIDTH-bit words from the FIFO's read port and emits them as OUT_WIDTH-bit slices on a valid/ready stream. Typical use: a 32-bit sample/command FIFO feeding a byte-wide transmitter (UART, SPI shifter, DAC byte bus).

Parameters:
DATA_WIDTH, 32, width of the FIFO word.
OUT_WIDTH, 8, width of each output slice. DATA_WIDTH must be an integer multiple of OUT_WIDTH, with RATIO = DATA_WIDTH/OUT_WIDTH >= 2.
MSB_FIRST, 0, slice order: 0 = least significant slice first, 1 = most significant slice first.
CNT_WIDTH, 16, width of the completed-word counter.

Ports:
clk  input  1  clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
fifo_data  input  DATA_WIDTH  FIFO head word; valid whenever fifo_empty=0 (show-ahead).
fifo_empty  input  1  FIFO empty flag.
fifo_read  output  1  pop strobe; the FIFO advances on the clock edge where this is 1.
out_data  output  OUT_WIDTH  current slice.
out_valid  output  1  out_data is valid.
out_ready  input  1  sink accepts the slice on an edge where out_valid and out_ready are both 1.
out_last  output  1  current slice is the final slice of its word.
busy  output  1  a word is held, i.e. state is SEND.
word_count  output  CNT_WIDTH  count of fully transmitted words; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - State goes to IDLE.
  - Slice index, holding register and word_count all clear to 0.
  - out_valid, out_last, busy, fifo_read and out_data are all 0 while in reset.
- States: IDLE, SEND.
- fifo_read timing:
  - fifo_read is combinational and equals `(state==IDLE & !fifo_empty) | (state==SEND & out_valid & out_ready & out_last & !fifo_empty)`.
  - fifo_read is never 1 while fifo_empty=1 or while reset=1.
- On any edge with fifo_read=1:
  - fifo_data is captured into the holding register.
  - The slice index is set to 0.
  - The next state is SEND.
- IDLE:
  - out_valid=0.
  - The block waits for fifo_empty=0.
  - First-slice latency is 1 cycle: out_valid rises on the cycle after fifo_empty falls.
- SEND, outputs:
  - out_valid=1.
  - out_data = slice[idx], where slice k is bits [k*OUT_WIDTH +: OUT_WIDTH] when MSB_FIRST=0, and slice RATIO-1-k when MSB_FIRST=1.
  - out_last = (idx == RATIO-1).
- SEND, handshake:
  - On an accept that is not the last slice, idx increments.
  - On an accept of the last slice, word_count increments. Then:
    - if fifo_empty=0, the next word is loaded on the same edge and the state stays SEND, giving zero bubble cycles;
    - otherwise the state goes to IDLE.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and idx hold stable. out_valid never drops without an accept.
- The slice register is independent of the FIFO after capture. FIFO writes or other changes to fifo_data during SEND have no effect on the held word.
- Reset mid-word: the partially sent word is discarded (it was already popped), and out_valid is 0 on the cycle after reset. After reset releases, the next word starts at slice 0.
- Throughput: with out_ready held at 1 and the FIFO never empty, one slice is accepted every cycle.
- word_count wraps from 2^CNT_WIDTH-1 to 0 without any flag.

Test Plan:
1. Single word, MSB_FIRST=0: push 0x44332211 with out_ready=1. Required response:
   - fifo_read=1 for exactly one cycle;
   - out_data sequence 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles;
   - out_last=1 only on 0x44;
   - word_count=1 afterwards, then IDLE with out_valid=0.
2. Back-to-back words: 0xA3A2A1A0 and 0xB3B2B1B0 already queued, out_ready=1. Required response:
   - 8 consecutive valid cycles, A0..A3 then B0..B3;
   - second fifo_read coincides with the A3 accept;
   - word_count=2.
3. Backpressure: drop out_ready for 3 cycles while 0x22 is presented. Required response:
   - out_data stays 0x22 and out_valid stays 1 for all 3 cycles;
   - 0x33 follows one cycle after out_ready returns.
4. MSB_FIRST=1 with word 0x44332211. Required response: 0x44, 0x33, 0x22, 0x11, with out_last on 0x11.
5. Reset after 2 slices of 0xDDCCBBAA are accepted. Required response:
   - next cycle: out_valid=0, busy=0, word_count=0;
   - a new word 0x04030201 then emits 0x01 first.
6. FIFO empty for 20 cycles with out_ready=1: fifo_read=0 and out_valid=0 throughout. Counter-wrap sub-case with CNT_WIDTH=2: send 5 words -> word_count=1.

Source files
------------

// File: rtl/fifo_word_unpacker_if.sv
// -----------------------------------------------------------------------------
// fifo_word_unpacker_if
// Groups the FIFO read port and the sliced output stream of fifo_word_unpacker.
//
// Signals:
//   fifo_data   FIFO head word (show-ahead, valid while fifo_empty = 0)
//   fifo_empty  FIFO empty flag
//   fifo_read   pop strobe towards the FIFO
//   out_data    current output slice
//   out_valid   out_data is valid
//   out_ready   sink accepts the slice when out_valid is also 1
//   out_last    current slice is the final slice of its word
//   busy        a word is held by the unpacker
//   word_count  number of fully transmitted words (wrapping)
//
// Modports:
//   master  the unpacker itself
//   slave   the environment (FIFO + sink)
// -----------------------------------------------------------------------------
interface fifo_word_unpacker_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_read;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  word_count;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        input  out_ready,
        output fifo_read,
        output out_data,
        output out_valid,
        output out_last,
        output busy,
        output word_count
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        output out_ready,
        input  fifo_read,
        input  out_data,
        input  out_valid,
        input  out_last,
        input  busy,
        input  word_count
    );
endinterface

// File: rtl/fifo_word_unpacker.sv
// -----------------------------------------------------------------------------
// fifo_word_unpacker
// Drains DATA_WIDTH-bit words from a show-ahead FIFO and emits them as
// OUT_WIDTH-bit slices on a valid/ready stream. The next word is popped on the
// same edge the last slice of the current word is accepted, so a continuously
// non-empty FIFO with a ready sink yields one slice per cycle.
//
// Parameters:
//   DATA_WIDTH  FIFO word width; must be an integer multiple of OUT_WIDTH
//   OUT_WIDTH   slice width; DATA_WIDTH / OUT_WIDTH must be >= 2
//   MSB_FIRST   0: least significant slice first, 1: most significant first
//   CNT_WIDTH   width of the completed-word counter
//
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-high reset
//   bus    fifo_word_unpacker_if.master (FIFO read port + output stream)
// -----------------------------------------------------------------------------
module fifo_word_unpacker #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_word_unpacker_if.master bus
);
    localparam int unsigned RATIO     = DATA_WIDTH / OUT_WIDTH;
    localparam int unsigned IDX_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [DATA_WIDTH-1:0] r_word;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [CNT_WIDTH-1:0]  r_word_count;

    logic [OUT_WIDTH-1:0]  w_slices [RATIO];
    logic                  w_fifo_read;
    logic                  w_out_valid;
    logic                  w_out_last;
    logic                  w_accept;
    logic                  w_last_accept;

    // Slice k of the transmit order, resolved at elaboration so the runtime
    // mux is a plain index by r_idx regardless of MSB_FIRST.
    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        localparam int unsigned Pos = MSB_FIRST ? (RATIO - 1 - g) : g;
        assign w_slices[g] = r_word[Pos*OUT_WIDTH +: OUT_WIDTH];
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        // A pop always (re)starts a word; this covers both leaving IDLE and
        // the zero-bubble reload on the last accept.
        if (w_fifo_read) begin
            w_state_next = StSend;
        end else if (w_last_accept) begin
            w_state_next = StIdle;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_fifo_read = 1'b0;
        case (r_state)
            StIdle: begin
                w_fifo_read = !bus.fifo_empty;
            end
            StSend: begin
                w_out_valid = 1'b1;
                w_out_last  = (r_idx == LAST_IDX);
                w_fifo_read = bus.out_ready && w_out_last && !bus.fifo_empty;
            end
            default: begin
                w_out_valid = 1'b0;
            end
        endcase
        // The state register only clears on the edge, so gate the outputs
        // for the whole time reset is high.
        if (reset) begin
            w_out_valid = 1'b0;
            w_out_last  = 1'b0;
            w_fifo_read = 1'b0;
        end
    end

    assign w_accept      = w_out_valid && bus.out_ready;
    assign w_last_accept = w_accept && w_out_last;

    // -------------------------------------------------------------------------
    // Datapath: holding register, slice index, completed-word counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word       <= '0;
            r_idx        <= '0;
            r_word_count <= '0;
        end else begin
            if (w_fifo_read) begin
                r_word <= bus.fifo_data;
                r_idx  <= '0;
            end else if (w_accept && !w_out_last) begin
                r_idx <= r_idx + IDX_WIDTH'(1);
            end
            if (w_last_accept) begin
                r_word_count <= r_word_count + CNT_WIDTH'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Interface outputs
    // -------------------------------------------------------------------------
    assign bus.fifo_read  = w_fifo_read;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_last   = w_out_last;
    assign bus.busy       = w_out_valid;
    assign bus.out_data   = w_out_valid ? w_slices[r_idx] : '0;
    assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// -----------------------------------------------------------------------------
// tb_fifo_word_unpacker
// Two unpackers (LSB-first/16-bit counter and MSB-first/2-bit counter) share
// one FIFO and one sink. A queue-of-slices model predicts every output on
// every falling edge; directed phases add literal expectations.
// -----------------------------------------------------------------------------
module tb_fifo_word_unpacker;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fifo_data = 32'h0;
    logic        fifo_empty = 1'b1;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    fifo_word_unpacker_if #(.DATA_WIDTH(32), .OUT_WIDTH(8), .CNT_WIDTH(16)) bus0 ();
    fifo_word_unpacker_if #(.DATA_WIDTH(32), .OUT_WIDTH(8), .CNT_WIDTH(2))  bus1 ();

    assign bus0.fifo_data  = fifo_data;
    assign bus0.fifo_empty = fifo_empty;
    assign bus0.out_ready  = out_ready;
    assign bus1.fifo_data  = fifo_data;
    assign bus1.fifo_empty = fifo_empty;
    assign bus1.out_ready  = out_ready;

    fifo_word_unpacker #(
        .DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0), .CNT_WIDTH(16)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    fifo_word_unpacker #(
        .DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1), .CNT_WIDTH(2)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Environment FIFO and reference model
    logic [31:0] fifo_q [$];
    logic [7:0]  q_lsb [$];     // remaining slices of held word, LSB-first order
    logic [7:0]  q_msb [$];     // same word, MSB-first order
    int          m_words = 0;   // words completed since last reset
    bit          pop_pending = 1'b0;
    bit          exp_read;
    bit          exp_valid;
    bit          exp_last;

    // Observation logs for the directed literal checks
    logic [7:0]  acc0 [$];
    logic [7:0]  acc1 [$];
    int          n_reads0 = 0;

    int          n_vec = 0;
    int          n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] acc_at(bit which, int i);
        if (which == 1'b0) begin
            return (i < acc0.size()) ? 32'(acc0[i]) : 32'hDEAD_BEEF;
        end
        return (i < acc1.size()) ? 32'(acc1[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic drive_fifo();
        if (fifo_q.size() != 0) begin
            fifo_empty = 1'b0;
            fifo_data  = fifo_q[0];
        end else begin
            fifo_empty = 1'b1;
            fifo_data  = $urandom;   // garbage while empty must never be captured
        end
    endtask

    task automatic push(logic [31:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        acc0.delete();
        acc1.delete();
        n_reads0 = 0;
    endtask

    // FIFO side: advance after the edge on which the pop was expected
    always @(posedge clk) begin
        #1;
        if (pop_pending && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
        end
        drive_fifo();
    end

    // Compare process: check both DUTs against the model, then advance model
    always @(negedge clk) begin
        exp_valid = !reset && (q_lsb.size() != 0);
        exp_last  = (q_lsb.size() == 1);
        exp_read  = !reset && !fifo_empty &&
                    (q_lsb.size() == 0 || (exp_last && out_ready));

        chk("fifo_read0", 32'(bus0.fifo_read), 32'(exp_read));
        chk("fifo_read1", 32'(bus1.fifo_read), 32'(exp_read));
        chk("out_valid0", 32'(bus0.out_valid), 32'(exp_valid));
        chk("out_valid1", 32'(bus1.out_valid), 32'(exp_valid));
        chk("busy0", 32'(bus0.busy), 32'(exp_valid));
        chk("busy1", 32'(bus1.busy), 32'(exp_valid));
        if (exp_valid) begin
            chk("out_data0", 32'(bus0.out_data), 32'(q_lsb[0]));
            chk("out_data1", 32'(bus1.out_data), 32'(q_msb[0]));
            chk("out_last0", 32'(bus0.out_last), 32'(exp_last));
            chk("out_last1", 32'(bus1.out_last), 32'(exp_last));
        end
        if (reset) begin
            chk("rst_out_data0", 32'(bus0.out_data), 32'h0);
            chk("rst_out_last0", 32'(bus0.out_last), 32'h0);
            chk("rst_out_data1", 32'(bus1.out_data), 32'h0);
        end else begin
            chk("word_count0", 32'(bus0.word_count), 32'(m_words) & 32'hFFFF);
            chk("word_count1", 32'(bus1.word_count), 32'(m_words) & 32'h3);
        end

        if (!reset && bus0.out_valid && out_ready) acc0.push_back(bus0.out_data);
        if (!reset && bus1.out_valid && out_ready) acc1.push_back(bus1.out_data);
        if (bus0.fifo_read) n_reads0++;

        if (reset) begin
            q_lsb.delete();
            q_msb.delete();
            m_words = 0;
        end else begin
            if (exp_valid && out_ready) begin
                void'(q_lsb.pop_front());
                void'(q_msb.pop_front());
                if (q_lsb.size() == 0) m_words++;
            end
            if (exp_read) begin
                for (int k = 0; k < 4; k++) begin
                    q_lsb.push_back(fifo_data[8*k +: 8]);
                    q_msb.push_back(fifo_data[8*(3-k) +: 8]);
                end
            end
        end
        pop_pending = exp_read;
    end

    initial begin
        drive_fifo();
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_valid", 32'(bus0.out_valid), 32'h0);
        chk("reset_count", 32'(bus0.word_count), 32'h0);

        // Single word, both slice orders
        clear_logs();
        out_ready = 1'b1;
        push(32'h4433_2211);
        repeat (7) tick();
        chk("t1_len", 32'(acc0.size()), 32'd4);
        chk("t1_s0", acc_at(0, 0), 32'h11);
        chk("t1_s1", acc_at(0, 1), 32'h22);
        chk("t1_s2", acc_at(0, 2), 32'h33);
        chk("t1_s3", acc_at(0, 3), 32'h44);
        chk("t4_m0", acc_at(1, 0), 32'h44);
        chk("t4_m3", acc_at(1, 3), 32'h11);
        chk("t1_reads", 32'(n_reads0), 32'd1);
        chk("t1_count", 32'(bus0.word_count), 32'd1);
        chk("t1_idle", 32'(bus0.out_valid), 32'h0);

        // Back-to-back words
        clear_logs();
        push(32'hA3A2_A1A0);
        push(32'hB3B2_B1B0);
        repeat (10) tick();
        for (int k = 0; k < 4; k++) begin
            chk("t2_a", acc_at(0, k), 32'hA0 + 32'(k));
            chk("t2_b", acc_at(0, k + 4), 32'hB0 + 32'(k));
        end
        chk("t2_reads", 32'(n_reads0), 32'd2);
        chk("t2_count", 32'(bus0.word_count), 32'd3);

        // Backpressure on the second slice
        push(32'h4433_2211);
        tick();
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_hold_data", 32'(bus0.out_data), 32'h22);
            chk("t3_hold_valid", 32'(bus0.out_valid), 32'h1);
        end
        out_ready = 1'b1;
        tick();
        chk("t3_next", 32'(bus0.out_data), 32'h33);
        repeat (4) tick();

        // Reset mid-word after two accepted slices
        push(32'hDDCC_BBAA);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_valid", 32'(bus0.out_valid), 32'h0);
        chk("t5_busy", 32'(bus0.busy), 32'h0);
        chk("t5_count", 32'(bus0.word_count), 32'h0);
        clear_logs();
        push(32'h0403_0201);
        repeat (7) tick();
        chk("t5_first", acc_at(0, 0), 32'h01);
        chk("t5_first_msb", acc_at(1, 0), 32'h04);
        chk("t5_len", 32'(acc0.size()), 32'd4);

        // Idle with empty FIFO, then counter wrap on the 2-bit instance
        clear_logs();
        repeat (20) tick();
        chk("t6_reads", 32'(n_reads0), 32'd0);
        chk("t6_valid", 32'(bus0.out_valid), 32'h0);
        for (int k = 0; k < 4; k++) push($urandom);
        repeat (25) tick();
        chk("t6_wrap", 32'(bus1.word_count), 32'd1);
        chk("t6_count", 32'(bus0.word_count), 32'd5);

        // Randomized traffic, backpressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset     = ($urandom_range(0, 499) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if (fifo_q.size() < 4 && $urandom_range(0, 2) == 0) push($urandom);
        end
        reset = 1'b0;
        repeat (30) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
